// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: control-word layout,
// instruction class codes and FSM state encodings.
package instr_sequencer_pkg;

    localparam int CW_DA_LSB = 13;
    localparam int CW_AA_LSB = 10;
    localparam int CW_BA_LSB = 7;
    localparam int CW_MB_BIT = 6;
    localparam int CW_FS_LSB = 2;
    localparam int CW_MD_BIT = 1;
    localparam int CW_RW_BIT = 0;
    localparam int REG_W     = 3;
    localparam int FS_W      = 4;

    typedef enum logic [2:0] {
        CLS_ALU  = 3'b000,
        CLS_ALUI = 3'b001,
        CLS_LD   = 3'b010,
        CLS_ST   = 3'b011,
        CLS_BRZ  = 3'b100,
        CLS_BRN  = 3'b101,
        CLS_JMP  = 3'b110,
        CLS_MISC = 3'b111
    } instr_cls_e;

    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } seq_state_e;

    function automatic logic [15:0] pack_ctrwrd(
        input logic [REG_W-1:0] da,
        input logic [REG_W-1:0] aa,
        input logic [REG_W-1:0] ba,
        input logic             mb,
        input logic [FS_W-1:0]  fs,
        input logic             md,
        input logic             rw
    );
        logic [15:0] w;
        w = '0;
        w[CW_DA_LSB +: REG_W] = da;
        w[CW_AA_LSB +: REG_W] = aa;
        w[CW_BA_LSB +: REG_W] = ba;
        w[CW_MB_BIT]          = mb;
        w[CW_FS_LSB +: FS_W]  = fs;
        w[CW_MD_BIT]          = md;
        w[CW_RW_BIT]          = rw;
        return w;
    endfunction

endpackage

// File: rtl/instr_sequencer_decode.sv
// Combinational instruction decoder: IR -> datapath control word, constant,
// write strobe and branch/halt qualifiers.
module instr_decode
    import instr_sequencer_pkg::*;
(
    input  logic [15:0] ir,
    output logic [15:0] ctrwrd,
    output logic [15:0] cin,
    output logic        mw,
    output logic        is_branch,
    output logic        br_uncond,
    output logic        br_on_n,
    output logic        is_halt,
    output logic [5:0]  off6
);

    logic [2:0] cls;
    logic [3:0] op;
    logic [2:0] dr;
    logic [2:0] sa;
    logic [2:0] sb;

    assign cls  = ir[15:13];
    assign op   = ir[12:9];
    assign dr   = ir[8:6];
    assign sa   = ir[5:3];
    assign sb   = ir[2:0];
    assign off6 = {ir[8:6], ir[2:0]};

    always_comb begin
        ctrwrd    = '0;
        cin       = '0;
        mw        = 1'b0;
        is_branch = 1'b0;
        br_uncond = 1'b0;
        br_on_n   = 1'b0;
        is_halt   = 1'b0;
        case (instr_cls_e'(cls))
            CLS_ALU:  ctrwrd = pack_ctrwrd(dr, sa, sb, 1'b0, op, 1'b0, 1'b1);
            CLS_ALUI: begin
                ctrwrd = pack_ctrwrd(dr, sa, sb, 1'b1, op, 1'b0, 1'b1);
                cin    = {13'b0, sb};
            end
            CLS_LD:   ctrwrd = pack_ctrwrd(dr, sa, 3'b000, 1'b0, 4'b0000, 1'b1, 1'b1);
            CLS_ST: begin
                ctrwrd = pack_ctrwrd(3'b000, sa, sb, 1'b0, 4'b0000, 1'b0, 1'b0);
                mw     = 1'b1;
            end
            CLS_BRZ: begin
                ctrwrd    = pack_ctrwrd(3'b000, sa, 3'b000, 1'b0, 4'b0000, 1'b0, 1'b0);
                is_branch = 1'b1;
            end
            CLS_BRN: begin
                ctrwrd    = pack_ctrwrd(3'b000, sa, 3'b000, 1'b0, 4'b0000, 1'b0, 1'b0);
                is_branch = 1'b1;
                br_on_n   = 1'b1;
            end
            CLS_JMP: begin
                is_branch = 1'b1;
                br_uncond = 1'b1;
            end
            CLS_MISC: is_halt = (op == OP_HALT);
            default:  ctrwrd = '0;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns PC, IR and the control FSM and
// presents the decoded control word to the datapath for one EXEC cycle.
//
// state    | meaning
// ST_IDLE  | waiting for run
// ST_FETCH | requesting instruction at PC until ack
// ST_EXEC  | one cycle driving decoded control word, branch resolve
// ST_HALT  | HALT executed, only reset leaves
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              run,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ack,
    output logic [15:0]       CTRWRD,
    output logic [15:0]       Cin,
    output logic              MW,
    input  logic              V,
    input  logic              C,
    input  logic              N,
    input  logic              Z,
    output logic              halted
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       ir_q;

    logic [15:0] dec_ctrwrd;
    logic [15:0] dec_cin;
    logic        dec_mw;
    logic        dec_is_branch;
    logic        dec_br_uncond;
    logic        dec_br_on_n;
    logic        dec_is_halt;
    logic [5:0]  dec_off6;

    logic              take_branch;
    logic [ADDR_W-1:0] off_ext;
    logic              unused_flags;

    instr_decode u_decode (
        .ir        (ir_q),
        .ctrwrd    (dec_ctrwrd),
        .cin       (dec_cin),
        .mw        (dec_mw),
        .is_branch (dec_is_branch),
        .br_uncond (dec_br_uncond),
        .br_on_n   (dec_br_on_n),
        .is_halt   (dec_is_halt),
        .off6      (dec_off6)
    );

    // V and C feed no branch condition in this instruction set.
    assign unused_flags = V ^ C;

    assign off_ext     = {{(ADDR_W-6){dec_off6[5]}}, dec_off6};
    assign take_branch = dec_is_branch & (dec_br_uncond | (dec_br_on_n ? N : Z));
    assign imem_addr   = pc_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_FETCH && imem_ack) begin
                ir_q <= imem_rdata;
                pc_q <= pc_q + ADDR_W'(1);
            end else if (state_q == ST_EXEC && take_branch) begin
                pc_q <= pc_q + off_ext;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        CTRWRD   = '0;
        Cin      = '0;
        MW       = 1'b0;
        halted   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                CTRWRD = dec_ctrwrd;
                Cin    = dec_cin;
                MW     = dec_mw;
                if (dec_is_halt)  state_d = ST_HALT;
                else if (run)     state_d = ST_FETCH;
                else              state_d = ST_IDLE;
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios with literal
// expectations, then randomized traffic checked against an instruction-level model.
module tb_instr_sequencer;

    logic        CLK = 1'b0;
    logic        RESET, run, imem_ack, V, C, N, Z;
    logic [15:0] imem_rdata;
    logic        imem_req, MW, halted;
    logic [15:0] imem_addr, CTRWRD, Cin;

    always #5 CLK = ~CLK;

    instr_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .CLK(CLK), .RESET(RESET), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .CTRWRD(CTRWRD), .Cin(Cin), .MW(MW),
        .V(V), .C(C), .N(N), .Z(Z), .halted(halted)
    );

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 fetching, 2 executing, 3 halted
    int          m_phase;
    logic [15:0] m_pc;
    logic [15:0] m_ir;

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_ctrwrd(input logic [15:0] ir);
        int cls, op, dr, sa, sb, w;
        cls = int'(ir) / 8192;
        op  = (int'(ir) / 512) % 16;
        dr  = (int'(ir) / 64) % 8;
        sa  = (int'(ir) / 8) % 8;
        sb  = int'(ir) % 8;
        case (cls)
            0:       w = dr * 8192 + sa * 1024 + sb * 128 + op * 4 + 1;
            1:       w = dr * 8192 + sa * 1024 + sb * 128 + 64 + op * 4 + 1;
            2:       w = dr * 8192 + sa * 1024 + 2 + 1;
            3:       w = sa * 1024 + sb * 128;
            4, 5:    w = sa * 1024;
            default: w = 0;
        endcase
        return 16'(w);
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_pc    = 16'h0000;
        m_ir    = 16'h0000;
    endtask

    task automatic model_step();
        int cls, off;
        bit take;
        case (m_phase)
            0: if (run) m_phase = 1;
            1: if (imem_ack) begin
                m_ir    = imem_rdata;
                m_pc    = m_pc + 16'd1;
                m_phase = 2;
            end
            2: begin
                cls  = int'(m_ir) / 8192;
                off  = ((int'(m_ir) / 64) % 8) * 8 + int'(m_ir) % 8;
                if (off >= 32) off = off - 64;
                take = (cls == 4 && Z) || (cls == 5 && N) || (cls == 6);
                if (take) m_pc = 16'((int'(m_pc) + off + 65536) % 65536);
                if (cls == 7 && ((int'(m_ir) / 512) % 16) == 15) m_phase = 3;
                else m_phase = run ? 1 : 0;
            end
            default: m_phase = 3;
        endcase
    endtask

    task automatic compare_model();
        chk16("imem_req", {15'b0, imem_req}, (m_phase == 1) ? 16'd1 : 16'd0);
        if (m_phase == 1) chk16("imem_addr", imem_addr, m_pc);
        chk16("CTRWRD", CTRWRD, (m_phase == 2) ? exp_ctrwrd(m_ir) : 16'h0000);
        chk16("Cin", Cin, (m_phase == 2 && m_ir[15:13] == 3'b001) ? {13'b0, m_ir[2:0]} : 16'h0000);
        chk16("MW", {15'b0, MW}, (m_phase == 2 && m_ir[15:13] == 3'b011) ? 16'd1 : 16'd0);
        chk16("halted", {15'b0, halted}, (m_phase == 3) ? 16'd1 : 16'd0);
    endtask

    task automatic drive(input logic rst, input logic r, input logic a,
                         input logic [15:0] d, input logic z, input logic n);
        @(negedge CLK);
        RESET      = rst;
        run        = r;
        imem_ack   = a;
        imem_rdata = d;
        Z          = z;
        N          = n;
        V          = 1'($urandom);
        C          = 1'($urandom);
        #1;
        if (!rst) model_reset();
        compare_model();
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RESET) model_step();
        else model_reset();
    endtask

    task automatic step(input logic rst, input logic r, input logic a,
                        input logic [15:0] d, input logic z, input logic n);
        drive(rst, r, a, d, z, n);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int halt_cnt;
        logic rst_r, run_r, ack_r;
        RESET = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        V = 0; C = 0; N = 0; Z = 0;
        model_reset();

        // reset and idle
        step(0, 0, 0, 16'h0, 0, 0);
        drive(0, 0, 1, 16'hFFFF, 0, 0);
        chk16("rst_ctrwrd", CTRWRD, 16'h0000);
        chk16("rst_req", {15'b0, imem_req}, 16'd0);
        chk16("rst_halted", {15'b0, halted}, 16'd0);
        tick();
        step(1, 0, 0, 16'h0, 0, 0);
        drive(1, 1, 0, 16'h0, 0, 0);
        tick();

        // ALU reg
        drive(1, 1, 1, 16'h1A9A, 0, 0);
        chk16("first_req", {15'b0, imem_req}, 16'd1);
        chk16("first_addr", imem_addr, 16'h0000);
        tick();
        drive(1, 1, 0, 16'h0, 0, 0);
        chk16("alu_ctrwrd", CTRWRD, 16'h4D35);
        tick();

        // immediate
        drive(1, 1, 1, 16'h2E5F, 0, 0);
        chk16("second_addr", imem_addr, 16'h0001);
        tick();
        drive(1, 1, 0, 16'h0, 0, 0);
        chk16("alui_cin", Cin, 16'h0007);
        chk16("alui_mb", {15'b0, CTRWRD[6]}, 16'd1);
        tick();

        // store
        step(1, 1, 1, 16'h6013, 0, 0);
        drive(1, 1, 0, 16'h0, 0, 0);
        chk16("st_mw", {15'b0, MW}, 16'd1);
        chk16("st_rw", {15'b0, CTRWRD[0]}, 16'd0);
        chk16("st_aa", {13'b0, CTRWRD[12:10]}, 16'd2);
        chk16("st_ba", {13'b0, CTRWRD[9:7]}, 16'd3);
        tick();

        // NOPs at 3 and 4, BRZ -2 at 5 taken
        step(1, 1, 1, 16'hE000, 0, 0);
        step(1, 1, 0, 16'h0, 0, 0);
        step(1, 1, 1, 16'hE000, 0, 0);
        step(1, 1, 0, 16'h0, 0, 0);
        drive(1, 1, 1, 16'h81C6, 0, 0);
        chk16("brz_addr", imem_addr, 16'h0005);
        tick();
        step(1, 1, 0, 16'h0, 1, 0);
        drive(1, 1, 0, 16'h0, 0, 0);
        chk16("brz_taken_addr", imem_addr, 16'h0004);
        tick();

        // NOP at 4, BRZ at 5 not taken
        step(1, 1, 1, 16'hE000, 0, 0);
        step(1, 1, 0, 16'h0, 0, 0);
        step(1, 1, 1, 16'h81C6, 0, 0);
        step(1, 1, 0, 16'h0, 0, 1);

        // wait states at 6
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 16'h0, 0, 0);
            chk16("wait_req", {15'b0, imem_req}, 16'd1);
            chk16("wait_addr", imem_addr, 16'h0006);
            tick();
        end

        // JMP -8 from 6 wraps to FFFF, NOP there wraps to 0000
        step(1, 1, 1, 16'hC1C0, 0, 0);
        step(1, 1, 0, 16'h0, 0, 0);
        drive(1, 1, 1, 16'hE000, 0, 0);
        chk16("jmp_wrap_addr", imem_addr, 16'hFFFF);
        tick();
        step(1, 1, 0, 16'h0, 0, 0);

        // HALT
        drive(1, 1, 1, 16'hFE00, 0, 0);
        chk16("pc_wrap_addr", imem_addr, 16'h0000);
        tick();
        step(1, 1, 0, 16'h0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 1, 16'($urandom), 1, 1);
            chk16("halt_stay", {15'b0, halted}, 16'd1);
            chk16("halt_req", {15'b0, imem_req}, 16'd0);
            tick();
        end

        // reset out of HALT, then reset mid-FETCH with a pending ack
        drive(0, 1, 0, 16'h0, 0, 0);
        chk16("halt_rst_halted", {15'b0, halted}, 16'd0);
        tick();
        step(1, 1, 0, 16'h0, 0, 0);
        step(1, 1, 1, 16'hE000, 0, 0);
        step(1, 1, 0, 16'h0, 0, 0);
        step(1, 1, 0, 16'h0, 0, 0);
        drive(0, 1, 1, 16'h81C6, 0, 0);
        chk16("midfetch_rst_addr", imem_addr, 16'h0000);
        chk16("midfetch_rst_req", {15'b0, imem_req}, 16'd0);
        tick();
        step(1, 0, 1, 16'hFE00, 0, 0);
        step(1, 1, 0, 16'h0, 0, 0);
        drive(1, 1, 0, 16'h0, 0, 0);
        chk16("after_rst_addr", imem_addr, 16'h0000);
        tick();

        // randomized traffic
        halt_cnt = 0;
        for (int i = 0; i < 4000; i++) begin
            halt_cnt = (m_phase == 3) ? halt_cnt + 1 : 0;
            rst_r = !(($urandom_range(0, 199) == 0) || halt_cnt > 4);
            run_r = ($urandom_range(0, 9) != 0);
            ack_r = ($urandom_range(0, 2) == 0);
            step(rst_r, run_r, ack_r, 16'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
